// File: rtl/pokemon_pkg.sv
// Shared types for the overworld character: facing direction and keyboard keycodes.
// color_mapper imports this for Direction as well.
package pokemon_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_A = 8'h04;

   function automatic logic key_valid(input logic [7:0] key);
      return (key == KEY_W) || (key == KEY_D) || (key == KEY_S) || (key == KEY_A);
   endfunction

   function automatic dir_t key_dir(input logic [7:0] key);
      dir_t d;
      case (key)
         KEY_D:   d = DIR_RIGHT;
         KEY_S:   d = DIR_DOWN;
         KEY_A:   d = DIR_LEFT;
         default: d = DIR_UP;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on VS: one-Clk tick per frame, however long VS stays high.
module frame_tick_gen (
   input  logic clk_i,
   input  logic rst_i,
   input  logic vs_i,
   output logic tick_o
);

   logic vs_q;

   // vs_q keeps tracking VS through reset so a VS already high at reset release is not a new frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_q <= vs_i;
      end else begin
         vs_q <= vs_i;
      end
   end

   assign tick_o = vs_i & ~vs_q;

endmodule

// File: rtl/character_motion_ctrl.sv
// Tile-quantised character walking driven by keycodes, advancing once per frame.
// Feeds Character_Moving/Direction and the camera offset to color_mapper.
//
// state | meaning
// IDLE  | at rest on a tile; decides turn, walk or blocked on each frame
// TURN  | facing a new direction for TURN_FRAMES frames before a walk may start
// WALK  | moving STEP_PX per frame until one full tile is covered
module character_motion_ctrl
   import pokemon_pkg::*;
#(
   parameter int TILE_PX     = 16,
   parameter int STEP_PX     = 2,
   parameter int TURN_FRAMES = 4,
   parameter int MAX_X       = 640,
   parameter int MAX_Y       = 480,
   parameter int START_X     = 0,
   parameter int START_Y     = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        VS,
   input  logic [7:0]  keycode,
   output logic        Character_Moving,
   output dir_t        Direction,
   output logic [10:0] topleftX,
   output logic [10:0] topleftY,
   output logic        step_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_WALK} state_t;

   localparam logic [7:0]  STEP_C    = 8'(STEP_PX);
   localparam logic [7:0]  TILE_C    = 8'(TILE_PX);
   localparam logic [7:0]  TURN_LAST = 8'(TURN_FRAMES - 1);
   localparam logic [10:0] STEP_O    = 11'(STEP_PX);
   localparam logic [11:0] TILE_E    = 12'(TILE_PX);
   localparam logic [11:0] MAX_X_E   = 12'(MAX_X);
   localparam logic [11:0] MAX_Y_E   = 12'(MAX_Y);

   state_t      state_q;
   dir_t        dir_q;
   logic [10:0] x_q, y_q;
   logic        moving_q, done_q;
   logic [7:0]  turn_cnt_q, px_cnt_q;

   logic        tick;
   logic        kvalid;
   dir_t        kdir;
   logic        legal_d;
   logic [10:0] x_walk_d, y_walk_d;
   logic [11:0] x_ext, y_ext;
   logic [7:0]  px_next_d;

   frame_tick_gen u_tick (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .vs_i   (VS),
      .tick_o (tick)
   );

   assign kvalid    = key_valid(keycode);
   assign kdir      = key_dir(keycode);
   assign x_ext     = {1'b0, x_q};
   assign y_ext     = {1'b0, y_q};
   assign px_next_d = px_cnt_q + STEP_C;

   // Legality uses the widened offset so the +TILE_PX sum cannot wrap.
   always_comb begin
      legal_d = 1'b0;
      case (kdir)
         DIR_UP:    legal_d = (y_ext >= TILE_E);
         DIR_DOWN:  legal_d = (y_ext + TILE_E <= MAX_Y_E);
         DIR_LEFT:  legal_d = (x_ext >= TILE_E);
         DIR_RIGHT: legal_d = (x_ext + TILE_E <= MAX_X_E);
         default:   legal_d = 1'b0;
      endcase
   end

   always_comb begin
      x_walk_d = x_q;
      y_walk_d = y_q;
      case (dir_q)
         DIR_UP:    y_walk_d = y_q - STEP_O;
         DIR_DOWN:  y_walk_d = y_q + STEP_O;
         DIR_LEFT:  x_walk_d = x_q - STEP_O;
         DIR_RIGHT: x_walk_d = x_q + STEP_O;
         default:   x_walk_d = x_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_UP;
         x_q        <= 11'(START_X);
         y_q        <= 11'(START_Y);
         moving_q   <= 1'b0;
         done_q     <= 1'b0;
         turn_cnt_q <= '0;
         px_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (tick) begin
            case (state_q)
               ST_IDLE: begin
                  moving_q <= 1'b0;
                  if (kvalid) begin
                     if (kdir != dir_q) begin
                        dir_q      <= kdir;
                        turn_cnt_q <= '0;
                        state_q    <= ST_TURN;
                     end else if (legal_d) begin
                        state_q  <= ST_WALK;
                        moving_q <= 1'b1;
                        px_cnt_q <= '0;
                     end
                  end
               end
               ST_TURN: begin
                  if (turn_cnt_q == TURN_LAST) begin
                     state_q <= ST_IDLE;
                  end else begin
                     turn_cnt_q <= turn_cnt_q + 8'd1;
                  end
               end
               ST_WALK: begin
                  x_q      <= x_walk_d;
                  y_q      <= y_walk_d;
                  px_cnt_q <= px_next_d;
                  if (px_next_d == TILE_C) begin
                     moving_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign Character_Moving = moving_q;
   assign Direction        = dir_q;
   assign topleftX         = x_q;
   assign topleftY         = y_q;
   assign step_done        = done_q;

endmodule
